// File: rtl/sargantana_icache_refill_unit.sv
`timescale 1ns/1ps
// Sargantana L1I line-refill engine: one fill request per miss, beats assembled in any order.
// Optional critical-word-first forwarding is built when ICACHE_REFILL_CWF_EN is defined.
module sargantana_icache_refill_unit #(
  parameter int PADDR_WIDTH = 40,
  parameter int LINE_WIDTH  = 256,
  parameter int BEAT_WIDTH  = 64,
  parameter int N_WAY       = 4,
  localparam int N_BEATS    = LINE_WIDTH / BEAT_WIDTH,
  localparam int BIDX_W     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1,
  localparam int WAY_W      = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   miss_valid_i,
  input  logic [PADDR_WIDTH-1:0] miss_paddr_i,
  input  logic [WAY_W-1:0]       miss_way_i,
  output logic                   miss_ready_o,
  input  logic                   kill_i,
  output logic                   ifill_req_valid_o,
  output logic [PADDR_WIDTH-1:0] ifill_req_paddr_o,
  output logic [WAY_W-1:0]       ifill_req_way_o,
  input  logic                   ifill_ack_i,
  input  logic                   ifill_beat_valid_i,
  input  logic [BIDX_W-1:0]      ifill_beat_idx_i,
  input  logic [BEAT_WIDTH-1:0]  ifill_beat_data_i,
  output logic                   line_valid_o,
  output logic [LINE_WIDTH-1:0]  line_data_o,
  output logic [PADDR_WIDTH-1:0] line_paddr_o,
  output logic [WAY_W-1:0]       line_way_o,
`ifdef ICACHE_REFILL_CWF_EN
  output logic                   crit_valid_o,
  output logic [BEAT_WIDTH-1:0]  crit_data_o,
`endif
  output logic                   busy_o
);

  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int BOFF_W = $clog2(BEAT_WIDTH / 8);
  localparam logic [PADDR_WIDTH-1:0] ALIGN_MASK =
    ~((PADDR_WIDTH'(1) << OFF_W) - PADDR_WIDTH'(1));

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DRAIN} state_t;

  state_t                                state_reg, state_next;
  logic [N_BEATS-1:0]                    mask_reg, mask_next, mask_after, beat_hit;
  logic [N_BEATS-1:0][BEAT_WIDTH-1:0]    line_reg;
  logic [PADDR_WIDTH-1:0]                paddr_reg;
  logic [WAY_W-1:0]                      way_reg;
  logic                                  accept, beat_take, mask_full;

  assign accept    = miss_valid_i && (state_reg == IDLE);
  assign beat_take = ifill_beat_valid_i &&
                     (state_reg == REQ || state_reg == WAIT || state_reg == DRAIN);

  // With a single beat per line the index carries no information and is ignored.
  for (genvar gi = 0; gi < N_BEATS; gi++) begin : g_hit
    assign beat_hit[gi] = beat_take &&
                          ((N_BEATS == 1) || (ifill_beat_idx_i == BIDX_W'(gi)));
  end

  assign mask_after = mask_reg | beat_hit;
  assign mask_full  = &mask_after;

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    case (state_reg)
      IDLE: begin
        if (miss_valid_i) begin
          state_next = REQ;
          mask_next  = '0;
        end
      end
      REQ: begin
        mask_next = mask_after;
        if (kill_i) begin
          // Once acked the memory side will still deliver the whole line.
          if (ifill_ack_i) state_next = mask_full ? IDLE : DRAIN;
          else             state_next = IDLE;
        end else if (ifill_ack_i) begin
          state_next = mask_full ? WRITE : WAIT;
        end
      end
      WAIT: begin
        mask_next = mask_after;
        if (mask_full)   state_next = kill_i ? IDLE : WRITE;
        else if (kill_i) state_next = DRAIN;
      end
      WRITE: state_next = IDLE;
      DRAIN: begin
        mask_next = mask_after;
        if (mask_full) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
      paddr_reg <= '0;
      way_reg   <= '0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      if (accept) begin
        paddr_reg <= miss_paddr_i & ALIGN_MASK;
        way_reg   <= miss_way_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      line_reg <= '0;
    end else begin
      for (int k = 0; k < N_BEATS; k++) begin
        if (beat_hit[k]) line_reg[k] <= ifill_beat_data_i;
      end
    end
  end

  assign miss_ready_o      = (state_reg == IDLE);
  assign busy_o            = (state_reg != IDLE);
  assign ifill_req_valid_o = (state_reg == REQ);
  assign ifill_req_paddr_o = paddr_reg;
  assign ifill_req_way_o   = way_reg;
  assign line_valid_o      = (state_reg == WRITE) && !kill_i;
  assign line_data_o       = line_reg;
  assign line_paddr_o      = paddr_reg;
  assign line_way_o        = way_reg;

`ifdef ICACHE_REFILL_CWF_EN
  logic [BIDX_W-1:0] crit_idx_reg, crit_idx_in;
  logic              crit_done_reg, crit_hit;

  if (N_BEATS > 1) begin : g_crit_idx
    assign crit_idx_in = miss_paddr_i[OFF_W-1:BOFF_W];
  end else begin : g_crit_idx_one
    assign crit_idx_in = '0;
  end

  assign crit_hit     = |(beat_hit & (N_BEATS'(1) << crit_idx_reg));
  assign crit_valid_o = crit_hit && !crit_done_reg && !kill_i &&
                        (state_reg == REQ || state_reg == WAIT);
  assign crit_data_o  = crit_valid_o ? ifill_beat_data_i : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      crit_idx_reg  <= '0;
      crit_done_reg <= 1'b0;
    end else if (accept) begin
      crit_idx_reg  <= crit_idx_in;
      crit_done_reg <= 1'b0;
    end else if (crit_valid_o) begin
      crit_done_reg <= 1'b1;
    end
  end
`else
  // No forwarding: the fetch path waits for line_valid_o.
`endif

endmodule

// File: tb/tb_sargantana_icache_refill_unit.sv
`timescale 1ns/1ps
// Bench for sargantana_icache_refill_unit: table vectors, random refills against a slot/seen-set model,
// hand sequences for kill/reset corners, plus 1-beat and 512/128 geometry instances.
module tb_sargantana_icache_refill_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // default geometry instance
  logic         miss_valid, miss_ready, kill, req_valid, ack, beat_valid, line_valid, busy;
  logic [39:0]  miss_paddr, req_paddr, line_paddr;
  logic [1:0]   miss_way, req_way, line_way, beat_idx;
  logic [63:0]  beat_data;
  logic [255:0] line_data;
`ifdef ICACHE_REFILL_CWF_EN
  logic         crit_valid;
  logic [63:0]  crit_data;
`endif

  // 1-beat instance
  logic         s1_miss_valid, s1_miss_ready, s1_req_valid, s1_ack, s1_beat_valid, s1_line_valid, s1_busy;
  logic [39:0]  s1_miss_paddr, s1_req_paddr, s1_line_paddr;
  logic [1:0]   s1_miss_way, s1_req_way, s1_line_way;
  logic [0:0]   s1_beat_idx;
  logic [63:0]  s1_beat_data, s1_line_data;
`ifdef ICACHE_REFILL_CWF_EN
  logic         s1_crit_valid;
  logic [63:0]  s1_crit_data;
`endif

  // 512/128 instance
  logic         s2_miss_valid, s2_miss_ready, s2_req_valid, s2_ack, s2_beat_valid, s2_line_valid, s2_busy;
  logic [39:0]  s2_miss_paddr, s2_req_paddr, s2_line_paddr;
  logic [1:0]   s2_miss_way, s2_req_way, s2_line_way, s2_beat_idx;
  logic [127:0] s2_beat_data;
  logic [511:0] s2_line_data;
`ifdef ICACHE_REFILL_CWF_EN
  logic         s2_crit_valid;
  logic [127:0] s2_crit_data;
`endif
  logic         s_kill;

  sargantana_icache_refill_unit dut (
    .clk_i(clk), .rstn_i(rst_n),
    .miss_valid_i(miss_valid), .miss_paddr_i(miss_paddr), .miss_way_i(miss_way), .miss_ready_o(miss_ready),
    .kill_i(kill),
    .ifill_req_valid_o(req_valid), .ifill_req_paddr_o(req_paddr), .ifill_req_way_o(req_way), .ifill_ack_i(ack),
    .ifill_beat_valid_i(beat_valid), .ifill_beat_idx_i(beat_idx), .ifill_beat_data_i(beat_data),
    .line_valid_o(line_valid), .line_data_o(line_data), .line_paddr_o(line_paddr), .line_way_o(line_way),
`ifdef ICACHE_REFILL_CWF_EN
    .crit_valid_o(crit_valid), .crit_data_o(crit_data),
`endif
    .busy_o(busy)
  );

  sargantana_icache_refill_unit #(.LINE_WIDTH(64), .BEAT_WIDTH(64)) dut_s1 (
    .clk_i(clk), .rstn_i(rst_n),
    .miss_valid_i(s1_miss_valid), .miss_paddr_i(s1_miss_paddr), .miss_way_i(s1_miss_way), .miss_ready_o(s1_miss_ready),
    .kill_i(s_kill),
    .ifill_req_valid_o(s1_req_valid), .ifill_req_paddr_o(s1_req_paddr), .ifill_req_way_o(s1_req_way), .ifill_ack_i(s1_ack),
    .ifill_beat_valid_i(s1_beat_valid), .ifill_beat_idx_i(s1_beat_idx), .ifill_beat_data_i(s1_beat_data),
    .line_valid_o(s1_line_valid), .line_data_o(s1_line_data), .line_paddr_o(s1_line_paddr), .line_way_o(s1_line_way),
`ifdef ICACHE_REFILL_CWF_EN
    .crit_valid_o(s1_crit_valid), .crit_data_o(s1_crit_data),
`endif
    .busy_o(s1_busy)
  );

  sargantana_icache_refill_unit #(.LINE_WIDTH(512), .BEAT_WIDTH(128)) dut_s2 (
    .clk_i(clk), .rstn_i(rst_n),
    .miss_valid_i(s2_miss_valid), .miss_paddr_i(s2_miss_paddr), .miss_way_i(s2_miss_way), .miss_ready_o(s2_miss_ready),
    .kill_i(s_kill),
    .ifill_req_valid_o(s2_req_valid), .ifill_req_paddr_o(s2_req_paddr), .ifill_req_way_o(s2_req_way), .ifill_ack_i(s2_ack),
    .ifill_beat_valid_i(s2_beat_valid), .ifill_beat_idx_i(s2_beat_idx), .ifill_beat_data_i(s2_beat_data),
    .line_valid_o(s2_line_valid), .line_data_o(s2_line_data), .line_paddr_o(s2_line_paddr), .line_way_o(s2_line_way),
`ifdef ICACHE_REFILL_CWF_EN
    .crit_valid_o(s2_crit_valid), .crit_data_o(s2_crit_data),
`endif
    .busy_o(s2_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // pulse counters, sampled mid-cycle
  int          lv_cnt = 0;
  int          crit_cnt = 0;
  logic [63:0] crit_last = '0;
  always @(negedge clk) begin
    if (line_valid === 1'b1) lv_cnt <= lv_cnt + 1;
`ifdef ICACHE_REFILL_CWF_EN
    if (crit_valid === 1'b1) begin
      crit_cnt  <= crit_cnt + 1;
      crit_last <= crit_data;
    end
`endif
  end

  typedef struct packed {
    logic [39:0]      pa;
    logic [1:0]       way;
    logic [3:0]       ack_dly;
    logic             beat_on_ack;
    logic             pat;
    logic [2:0]       nb;
    logic [5:0][1:0]  ord;
    logic [2:0]       kill_after;   // 7 = no kill
    logic             exp_line;
    logic [39:0]      exp_req_pa;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [5:0][1:0] mk_ord(input int a, input int b, input int c, input int d, input int e);
    logic [5:0][1:0] o;
    o = '0;
    o[0] = 2'(a); o[1] = 2'(b); o[2] = 2'(c); o[3] = 2'(d); o[4] = 2'(e);
    return o;
  endfunction

  // One refill on the default instance; the model is "last write per slot wins, done when every slot seen".
  task automatic run_txn(input vec_t v, input string name);
    logic [63:0]  slot [4];
    bit           seen [4];
    logic [255:0] exp_data;
    logic [63:0]  d, exp_crit_data;
    int           lv0, cr0, guard, idx, exp_crit;
    bit           killed, crit_arrived;
    lv0 = lv_cnt; cr0 = crit_cnt; exp_crit = 0; exp_crit_data = '0;
    killed = 0; crit_arrived = 0;
    for (int k = 0; k < 4; k++) begin slot[k] = '0; seen[k] = 0; end
    guard = 0;
    while (miss_ready !== 1'b1 && guard < 20) begin cyc(); guard++; end
    check({name, "/ready"}, miss_ready, 1'b1);
    check({name, "/idle_busy"}, busy, 1'b0);
    miss_valid = 1; miss_paddr = v.pa; miss_way = v.way;
    cyc();
    miss_valid = 0; miss_paddr = 40'({$urandom(), $urandom()}); miss_way = 2'($urandom());
    check({name, "/req_valid"}, req_valid, 1'b1);
    check({name, "/req_paddr"}, req_paddr, v.exp_req_pa);
    check({name, "/req_way"}, req_way, v.way);
    repeat (int'(v.ack_dly)) cyc();
    check({name, "/req_hold"}, {req_valid, req_paddr}, {1'b1, v.exp_req_pa});
    ack = 1;
    if (!v.beat_on_ack) begin cyc(); ack = 0; end
    for (int bi = 0; bi < int'(v.nb); bi++) begin
      if (bi > 0 || !v.beat_on_ack) begin
        if (!killed && int'(v.kill_after) == bi) begin
          kill = 1; cyc(); kill = 0; killed = 1;
          check({name, "/drain_busy"}, {busy, miss_ready}, 2'b10);
        end
        repeat ($urandom_range(0, 1)) cyc();
      end
      idx = int'(v.ord[bi]);
      if (v.pat) d = seen[idx] ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h1111_1111_1111_1111 * 64'(idx + 1);
      else       d = {$urandom(), $urandom()};
      if (!crit_arrived && idx == int'(v.pa[4:3])) begin
        crit_arrived = 1;
        if (!killed) begin exp_crit = 1; exp_crit_data = d; end
      end
      slot[idx] = d; seen[idx] = 1;
      beat_valid = 1; beat_idx = 2'(idx); beat_data = d;
      cyc();
      beat_valid = 0; ack = 0; beat_data = '0;
    end
    if (v.exp_line) begin
      for (int k = 0; k < 4; k++) exp_data[k*64 +: 64] = slot[k];
      check({name, "/line_valid"}, line_valid, 1'b1);
      check({name, "/line_data"}, line_data, exp_data);
      check({name, "/line_paddr"}, line_paddr, v.exp_req_pa);
      check({name, "/line_way"}, line_way, v.way);
      cyc();
      check({name, "/line_pulse_end"}, line_valid, 1'b0);
    end
    check({name, "/ready_after"}, {miss_ready, busy}, 2'b10);
    check({name, "/line_count"}, 512'(lv_cnt - lv0), 512'(v.exp_line));
`ifdef ICACHE_REFILL_CWF_EN
    check({name, "/crit_count"}, 512'(crit_cnt - cr0), 512'(exp_crit));
    if (exp_crit == 1) check({name, "/crit_data"}, crit_last, exp_crit_data);
`endif
    $display("txn %s pa=%h way=%0d beats=%0d kill_after=%0d line=%0d", name, v.pa, v.way, v.nb, v.kill_after, v.exp_line);
  endtask

  task automatic send_beats(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      beat_valid = 1; beat_idx = 2'(k); beat_data = {$urandom(), $urandom()};
      cyc();
      beat_valid = 0;
    end
  endtask

  vec_t v;
  int   perm [4];
  int   p, dupval, pos, lv0, cr0, tmp, j;
  logic [127:0] s2_slot [4];
  logic [511:0] s2_exp;
  logic [63:0]  s1_d;

  initial begin
    rst_n = 0;
    miss_valid = 0; miss_paddr = '0; miss_way = '0; kill = 0; ack = 0;
    beat_valid = 0; beat_idx = '0; beat_data = '0;
    s1_miss_valid = 0; s1_miss_paddr = '0; s1_miss_way = '0; s1_ack = 0;
    s1_beat_valid = 0; s1_beat_idx = '0; s1_beat_data = '0;
    s2_miss_valid = 0; s2_miss_paddr = '0; s2_miss_way = '0; s2_ack = 0;
    s2_beat_valid = 0; s2_beat_idx = '0; s2_beat_data = '0;
    s_kill = 0;

    tbl[0] = '{pa: 40'h00_8000_1234, way: 2'd2, ack_dly: 4'd0, beat_on_ack: 1'b0, pat: 1'b1, nb: 3'd4,
               ord: mk_ord(0, 1, 2, 3, 0), kill_after: 3'd7, exp_line: 1'b1, exp_req_pa: 40'h00_8000_1220};
    tbl[1] = '{pa: 40'h00_0000_4008, way: 2'd1, ack_dly: 4'd1, beat_on_ack: 1'b0, pat: 1'b1, nb: 3'd5,
               ord: mk_ord(2, 0, 3, 0, 1), kill_after: 3'd7, exp_line: 1'b1, exp_req_pa: 40'h00_0000_4000};
    tbl[2] = '{pa: 40'h12_3456_7890, way: 2'd0, ack_dly: 4'd0, beat_on_ack: 1'b0, pat: 1'b0, nb: 3'd4,
               ord: mk_ord(0, 1, 2, 3, 0), kill_after: 3'd2, exp_line: 1'b0, exp_req_pa: 40'h12_3456_7880};
    tbl[3] = '{pa: 40'hFF_FFFF_FFFF, way: 2'd3, ack_dly: 4'd2, beat_on_ack: 1'b1, pat: 1'b0, nb: 3'd4,
               ord: mk_ord(3, 2, 1, 0, 0), kill_after: 3'd7, exp_line: 1'b1, exp_req_pa: 40'hFF_FFFF_FFE0};
    tbl[4] = '{pa: 40'h00_1000_0018, way: 2'd1, ack_dly: 4'd0, beat_on_ack: 1'b0, pat: 1'b1, nb: 3'd4,
               ord: mk_ord(0, 1, 2, 3, 0), kill_after: 3'd7, exp_line: 1'b1, exp_req_pa: 40'h00_1000_0000};
    tbl[5] = '{pa: 40'h00_2000_0038, way: 2'd2, ack_dly: 4'd1, beat_on_ack: 1'b0, pat: 1'b0, nb: 3'd4,
               ord: mk_ord(0, 1, 2, 3, 0), kill_after: 3'd3, exp_line: 1'b0, exp_req_pa: 40'h00_2000_0020};

    repeat (2) cyc();
    check("reset/ready", {miss_ready, busy, req_valid, line_valid}, 4'b1000);
    check("reset/line_data", line_data, 256'd0);
    check("reset/addr_way", {req_paddr, req_way, line_paddr, line_way}, 84'd0);
    check("reset/s1_s2_ready", {s1_miss_ready, s1_busy, s2_miss_ready, s2_busy}, 4'b1010);
    rst_n = 1;
    cyc();

    for (int t = 0; t < 6; t++) run_txn(tbl[t], $sformatf("tbl%0d", t));

    // kill in REQ without ack: request dropped, next miss taken at once
    miss_valid = 1; miss_paddr = 40'h00_0ABC_DE40; miss_way = 2'd3;
    cyc();
    miss_valid = 0; kill = 1;
    #1 check("killreq/req_still", req_valid, 1'b1);
    cyc();
    kill = 0;
    check("killreq/req_drop", {req_valid, miss_ready, busy}, 3'b010);
    $display("txn killreq pa=%h dropped before ack", 40'h00_0ABC_DE40);
    run_txn(tbl[0], "after_killreq");

    // kill in IDLE with miss (accepted), then kill together with ack (drain)
    lv0 = lv_cnt;
    kill = 1; miss_valid = 1; miss_paddr = 40'h00_3333_0010; miss_way = 2'd1;
    cyc();
    kill = 0; miss_valid = 0;
    check("idlekill/accepted", req_valid, 1'b1);
    ack = 1; kill = 1;
    cyc();
    ack = 0; kill = 0;
    check("ackkill/drain", {busy, req_valid, miss_ready}, 3'b100);
    send_beats(0, 2);
    check("ackkill/busy_before_last", busy, 1'b1);
    send_beats(3, 3);
    check("ackkill/idle_after", {miss_ready, busy}, 2'b10);
    check("ackkill/no_line", 512'(lv_cnt - lv0), 512'd0);
    $display("txn ackkill pa=%h drained 4 beats", 40'h00_3333_0010);

    // kill during the write cycle suppresses the line
    lv0 = lv_cnt;
    miss_valid = 1; miss_paddr = 40'h00_4444_0000; miss_way = 2'd0;
    cyc();
    miss_valid = 0; ack = 1;
    cyc();
    ack = 0;
    send_beats(0, 3);
    kill = 1;
    @(negedge clk);
    check("writekill/line_suppressed", line_valid, 1'b0);
    cyc();
    kill = 0;
    check("writekill/idle", {miss_ready, busy}, 2'b10);
    check("writekill/no_line", 512'(lv_cnt - lv0), 512'd0);
    $display("txn writekill pa=%h line suppressed", 40'h00_4444_0000);

    // reset mid-WAIT, late beats must be ignored
    lv0 = lv_cnt; cr0 = crit_cnt;
    miss_valid = 1; miss_paddr = 40'h00_5555_0018; miss_way = 2'd3;
    cyc();
    miss_valid = 0; ack = 1;
    cyc();
    ack = 0;
    send_beats(0, 1);
    rst_n = 0;
    #1;
    check("rstmid/state", {miss_ready, busy, req_valid, line_valid}, 4'b1000);
    check("rstmid/regs", {line_data, line_paddr, line_way}, 298'd0);
    cyc();
    rst_n = 1;
    send_beats(2, 3);
    cyc();
    check("rstmid/late_beats", {miss_ready, busy}, 2'b10);
    check("rstmid/buffer_clear", line_data, 256'd0);
    check("rstmid/no_line", 512'(lv_cnt - lv0), 512'd0);
    check("rstmid/no_crit", 512'(crit_cnt - cr0), 512'd0);
    $display("txn rstmid pa=%h reset after 2 beats", 40'h00_5555_0018);

    // randomized refills
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 4; k++) perm[k] = k;
      for (int k = 3; k > 0; k--) begin
        j = $urandom_range(0, k); tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
      end
      v = '0;
      v.pa = {8'($urandom()), 32'($urandom())};
      v.way = 2'($urandom());
      v.ack_dly = 4'($urandom_range(0, 3));
      v.beat_on_ack = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      dupval = (p > 0) ? perm[$urandom_range(0, p - 1)] : 0;
      pos = 0;
      for (int k = 0; k < 4; k++) begin
        if (p > 0 && k == p) begin v.ord[pos] = 2'(dupval); pos++; end
        v.ord[pos] = 2'(perm[k]); pos++;
      end
      v.nb = 3'(pos);
      v.kill_after = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, pos - 1)) : 3'd7;
      v.exp_line = (v.kill_after == 3'd7);
      v.exp_req_pa = (v.pa >> 5) << 5;
      run_txn(v, $sformatf("rnd%0d", r));
    end

    // 1-beat line: index ignored, line one cycle after its beat
    check("s1/ready", s1_miss_ready, 1'b1);
    s1_miss_valid = 1; s1_miss_paddr = 40'h12_3456_767D; s1_miss_way = 2'd1;
    cyc();
    s1_miss_valid = 0;
    check("s1/req", {s1_req_valid, s1_req_paddr}, {1'b1, 40'h12_3456_7678});
    s1_ack = 1;
    cyc();
    s1_ack = 0;
    s1_d = {$urandom(), $urandom()};
    s1_beat_valid = 1; s1_beat_idx = 1'b1; s1_beat_data = s1_d;
    cyc();
    s1_beat_valid = 0;
    check("s1/line_valid", s1_line_valid, 1'b1);
    check("s1/line_data", s1_line_data, s1_d);
    check("s1/line_addr_way", {s1_line_paddr, s1_line_way}, {40'h12_3456_7678, 2'd1});
    cyc();
    check("s1/done", {s1_line_valid, s1_miss_ready}, 2'b01);
    $display("txn s1 pa=%h data=%h", 40'h12_3456_767D, s1_d);

    // 512-bit line, 128-bit beats, out of order
    s2_miss_valid = 1; s2_miss_paddr = 40'h00_8000_1234; s2_miss_way = 2'd2;
    cyc();
    s2_miss_valid = 0;
    check("s2/req", {s2_req_valid, s2_req_paddr, s2_req_way}, {1'b1, 40'h00_8000_1200, 2'd2});
    s2_ack = 1;
    cyc();
    s2_ack = 0;
    for (int k = 0; k < 4; k++) begin
      j = (k == 0) ? 3 : (k == 1) ? 1 : (k == 2) ? 0 : 2;
      s2_slot[j] = {$urandom(), $urandom(), $urandom(), $urandom()};
      s2_beat_valid = 1; s2_beat_idx = 2'(j); s2_beat_data = s2_slot[j];
      cyc();
      s2_beat_valid = 0;
      if (k == 2) check("s2/not_yet", {s2_line_valid, s2_busy}, 2'b01);
    end
    for (int k = 0; k < 4; k++) s2_exp[k*128 +: 128] = s2_slot[k];
    check("s2/line_valid", s2_line_valid, 1'b1);
    check("s2/line_data", s2_line_data, s2_exp);
    check("s2/line_addr", s2_line_paddr, 40'h00_8000_1200);
    cyc();
    check("s2/done", {s2_line_valid, s2_miss_ready}, 2'b01);
    $display("txn s2 pa=%h order 3,1,0,2", 40'h00_8000_1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_refill_unit.md
Name: sargantana_icache_refill_unit

Overview:
Parametrised line-refill engine for the Sargantana L1 instruction cache, generalising the fixed 256-bit / 4-beat fill path to any line width and beat count. Accepts a miss from the icache controller, issues one fill request to the memory side, and assembles beats (any arrival order) into a full line. It then presents one write-back beat to the tag/data arrays. Handles kill (flush) mid-refill by draining outstanding beats without writing the cache.

Parameters:
PADDR_WIDTH, 40, physical address width (drac_pkg::PHY_ADDR_SIZE)
LINE_WIDTH, 256, cache line width in bits (power of two, >= BEAT_WIDTH)
BEAT_WIDTH, 64, fill data beat width in bits; N_BEATS = LINE_WIDTH/BEAT_WIDTH, BIDX_W = max(1, $clog2(N_BEATS))
N_WAY, 4, associativity; WAY_W = max(1, $clog2(N_WAY))

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
miss_valid_i  in  1  refill request from icache controller
miss_paddr_i  in  PADDR_WIDTH  missing physical address (any byte offset)
miss_way_i  in  WAY_W  victim way
miss_ready_o  out  1  unit idle, can accept miss
kill_i  in  1  abandon current refill (pipeline flush)
ifill_req_valid_o  out  1  fill request to memory side
ifill_req_paddr_o  out  PADDR_WIDTH  line-aligned address (low $clog2(LINE_WIDTH/8) bits zero)
ifill_req_way_o  out  WAY_W  way to replace
ifill_ack_i  in  1  memory side accepted request
ifill_beat_valid_i  in  1  one data beat valid
ifill_beat_idx_i  in  BIDX_W  beat position within line
ifill_beat_data_i  in  BEAT_WIDTH  beat data
line_valid_o  out  1  assembled line ready to write (one-cycle pulse)
line_data_o  out  LINE_WIDTH  assembled line, beat k at bits [k*BEAT_WIDTH +: BEAT_WIDTH]
line_paddr_o  out  PADDR_WIDTH  line-aligned address of line
line_way_o  out  WAY_W  target way
busy_o  out  1  any state other than IDLE

Behaviour:
- Reset: state IDLE; all outputs 0 except miss_ready_o=1; beat mask, line buffer, address, way registers cleared.
- FSM IDLE -> REQ on miss_valid_i&miss_ready_o (latch aligned paddr, way; clear beat mask). miss_ready_o = (state==IDLE).
- REQ: ifill_req_valid_o=1, paddr/way stable until ifill_ack_i; ack -> WAIT. Beats arriving in REQ (same cycle as ack or earlier) are accepted and recorded.
- WAIT: each beat_valid writes data into slot beat_idx, sets mask bit. When mask becomes all-ones (including the cycle the last beat arrives) -> WRITE next cycle.
- WRITE: line_valid_o=1 for exactly one cycle with data/paddr/way; -> IDLE. Latency: last beat at cycle t -> line_valid_o at t+1; miss_ready_o at t+2.
- Duplicate beat index: overwrites data, mask unchanged; no error.
- kill_i in REQ before ack: drop request, -> IDLE next cycle (ifill_req_valid_o deasserts). kill_i in REQ with ack same cycle, or in WAIT -> DRAIN. kill_i in WRITE: line_valid_o suppressed, -> IDLE. kill_i in IDLE/DRAIN: no effect; a simultaneous miss_valid_i in IDLE is still accepted.
- DRAIN: keep absorbing beats, no line_valid_o; when mask full -> IDLE. busy_o=1 throughout.
- N_BEATS=1: first beat completes line; BIDX_W=1, idx ignored.
- Reset asserted mid-refill: immediate return to IDLE, all state cleared; late beats arriving in IDLE are ignored.

Optional Feature:
ICACHE_REFILL_CWF_EN: adds outputs crit_valid_o (1) and crit_data_o (BEAT_WIDTH). Critical beat = miss_paddr_i[$clog2(LINE_WIDTH/8)-1 : $clog2(BEAT_WIDTH/8)] latched at accept. Arrival of that beat in REQ/WAIT (not DRAIN, not killed same cycle) -> crit_valid_o pulses the same cycle, combinationally forwarding ifill_beat_data_i; once per refill. Without the macro: ports absent, no forwarding; fetch waits for line_valid_o.

Test Plan:
- Defaults; miss paddr 0x80001234 way 2; ack next cycle; beats 0..3 in order, data 0x11..,0x22..,0x33..,0x44.. -> ifill_req_paddr_o=0x80001220, line_valid_o one cycle after beat 3, line_data_o={44,33,22,11}, line_way_o=2.
- Beats out of order 2,0,3,1 plus duplicate beat 0 (new data 0xAA) -> single line_valid_o after beat 1; slot 0 holds 0xAA.
- kill_i in WAIT after 2 beats -> no line_valid_o; busy_o stays 1 until 4th beat; miss_ready_o=1 the following cycle.
- kill_i in REQ with no ack -> ifill_req_valid_o drops next cycle, IDLE; new miss accepted immediately.
- LINE_WIDTH=512, BEAT_WIDTH=128 (4 beats) and LINE_WIDTH=BEAT_WIDTH=64 (1 beat) -> correct placement; 1-beat case line_valid_o one cycle after its beat.
- CWF_EN, miss offset 0x18 (beat 3 of 4 at 64-bit) -> crit_valid_o exactly once, on beat-3 arrival, crit_data_o = that beat; rstn_i pulsed mid-WAIT -> all outputs reset, later beats ignored.
